// File: rtl/turn_timer_pkg.sv
// turn_timer_pkg
//   Shared types and defaults for the per-turn countdown timer.
//   timer_state_t    : FSM state encoding (IDLE, RUN, EXPIRED)
//   DEF_CLK_FREQ_HZ  : default clock frequency, in cycles per second
//   DEF_TURN_SECONDS : default turn length, in seconds
//   WARN_SECONDS     : threshold at or below which the optional warn output is asserted
//   warn_limit()     : effective warn threshold for a given turn length
package turn_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

   localparam int DEF_CLK_FREQ_HZ  = 50_000_000;
   localparam int DEF_TURN_SECONDS = 15;
   localparam int WARN_SECONDS     = 3;

   // For turns shorter than the warn window, warn covers the whole turn.
   function automatic int warn_limit(input int turn_seconds);
      return (turn_seconds < WARN_SECONDS) ? turn_seconds : WARN_SECONDS;
   endfunction

endpackage

// File: rtl/turn_timer_tick_gen.sv
// tick_gen
//   One-second prescaler. It counts clock cycles while enabled and raises tick
//   for exactly one cycle when the count reaches CLK_FREQ_HZ-1. On that cycle
//   the count wraps to 0.
//   clk    : clock
//   rst    : asynchronous reset, active low
//   clear  : forces the count to 0 on the next edge (takes priority over enable)
//   enable : counts while high
//   tick   : high during the final cycle of each one-second period
module tick_gen
   import turn_timer_pkg::*;
#(
   parameter  int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   localparam int PRE_W       = $clog2(CLK_FREQ_HZ)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_FREQ_HZ - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   assign tick = enable && (pre_q == PRE_TC);

   always_comb begin
      pre_d = pre_q;
      if (clear) begin
         pre_d = '0;
      end else if (enable) begin
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/turn_timer.sv
// turn_timer
//   Per-turn countdown timer. It counts down whole seconds while playState is
//   high and drives timeExpired for the game FSM.
//   clk         : clock; all state changes happen on its rising edge
//   rst         : asynchronous reset, active low
//   playState   : high while the game FSM is in PLAY
//   playerMov   : player committed a move this cycle
//   timeExpired : one-cycle registered pulse when the turn time runs out
//   secondsLeft : remaining whole seconds, registered
//   running     : high while counting (RUN)
//   warn        : (only when TURN_TIMER_WARN_EN is defined) registered; high in
//                 RUN while secondsLeft <= min(WARN_SECONDS, TURN_SECONDS)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | turn not running; seconds held at full, prescaler held at 0
//   RUN     | counting down; a move or the end of the turn reloads the timer
//   EXPIRED | time ran out; holds 0 until playState drops
module turn_timer
   import turn_timer_pkg::*;
#(
   parameter  int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
   parameter  int TURN_SECONDS = DEF_TURN_SECONDS,
   localparam int SEC_W        = $clog2(TURN_SECONDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             playState,
   input  logic             playerMov,
   output logic             timeExpired,
   output logic [SEC_W-1:0] secondsLeft,
   output logic             running
`ifdef TURN_TIMER_WARN_EN
   ,
   output logic             warn
`endif
);

   localparam logic [SEC_W-1:0] SEC_FULL = SEC_W'(TURN_SECONDS);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

   timer_state_t     state_q;
   timer_state_t     state_d;
   logic [SEC_W-1:0] sec_q;
   logic [SEC_W-1:0] sec_d;
   logic             expired_q;
   logic             expired_d;
   logic             tick;
   logic             pre_clear;
   logic             pre_enable;

   // The prescaler is cleared whenever the next state is not RUN. This
   // returns it to 0 on the same edge that leaves RUN, so every new turn
   // starts from a full second. tick does not depend on clear, so there is
   // no combinational loop.
   assign pre_enable = (state_q == RUN);
   assign pre_clear  = (state_d != RUN);

   tick_gen #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (pre_clear),
      .enable(pre_enable),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      expired_d = 1'b0;
      case (state_q)
         IDLE: begin
            sec_d = SEC_FULL;
            if (playState && !playerMov) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A move, or the turn ending, takes priority over a coincident
            // final tick.
            if (playerMov || !playState) begin
               state_d = IDLE;
               sec_d   = SEC_FULL;
            end else if (tick) begin
               if (sec_q <= SEC_ONE) begin
                  state_d   = EXPIRED;
                  sec_d     = '0;
                  expired_d = 1'b1;
               end else begin
                  sec_d = sec_q - SEC_ONE;
               end
            end
         end
         EXPIRED: begin
            sec_d = '0;
            if (!playState) begin
               state_d = IDLE;
               sec_d   = SEC_FULL;
            end
         end
         default: begin
            state_d = IDLE;
            sec_d   = SEC_FULL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sec_q     <= SEC_FULL;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_q     <= sec_d;
         expired_q <= expired_d;
      end
   end

   assign timeExpired = expired_q;
   assign secondsLeft = sec_q;
   assign running     = (state_q == RUN);

`ifdef TURN_TIMER_WARN_EN
   localparam logic [SEC_W-1:0] WARN_LIM = SEC_W'(warn_limit(TURN_SECONDS));

   logic warn_q;
   logic warn_d;

   // Computed from the next-state values so that warn moves on the same edge
   // as secondsLeft.
   always_comb begin
      warn_d = (state_d == RUN) && (sec_d <= WARN_LIM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_d;
      end
   end

   assign warn = warn_q;
`endif

endmodule

// File: tb/tb_turn_timer.sv
module tb_turn_timer;

   localparam int CLK_HZ = 4;
   localparam int TURN_S = 3;
   localparam int SW     = $clog2(TURN_S + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          playState = 1'b0;
   logic          playerMov = 1'b0;
   logic          timeExpired;
   logic          running;
   logic [SW-1:0] secondsLeft;
`ifdef TURN_TIMER_WARN_EN
   logic          warn;
`endif

   int total = 0;
   int bad = 0;
   int dut_pulses = 0;
   int mdl_pulses = 0;

   always #5 clk = ~clk;

   turn_timer #(
      .CLK_FREQ_HZ (CLK_HZ),
      .TURN_SECONDS(TURN_S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .playState  (playState),
      .playerMov  (playerMov),
      .timeExpired(timeExpired),
      .secondsLeft(secondsLeft),
      .running    (running)
`ifdef TURN_TIMER_WARN_EN
      ,
      .warn       (warn)
`endif
   );

   // Reference model: tracks elapsed cycles since the turn began. The
   // remaining seconds are derived arithmetically from that count.
   typedef struct {
      bit run;
      bit exp;
      bit pulse;
      int cyc;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_next(input mdl_t c, input bit ps, input bit pm);
      mdl_t n;
      n = c;
      n.pulse = 1'b0;
      if (c.run) begin
         if (pm || !ps) begin
            n.run = 1'b0;
         end else begin
            n.cyc = c.cyc + 1;
            if (n.cyc == TURN_S * CLK_HZ) begin
               n.run   = 1'b0;
               n.exp   = 1'b1;
               n.pulse = 1'b1;
            end
         end
      end else if (c.exp) begin
         if (!ps) n.exp = 1'b0;
      end else if (ps && !pm) begin
         n.run = 1'b1;
         n.cyc = 0;
      end
      return n;
   endfunction

   function automatic int exp_sec(input mdl_t c);
      if (c.run) return TURN_S - c.cyc / CLK_HZ;
      if (c.exp) return 0;
      return TURN_S;
   endfunction

   function automatic bit exp_warn(input mdl_t c);
      int lim;
      lim = (TURN_S < 3) ? TURN_S : 3;
      return c.run && ((TURN_S - c.cyc / CLK_HZ) <= lim);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= '{run: 1'b0, exp: 1'b0, pulse: 1'b0, cyc: 0};
      else      m <= mdl_next(m, playState, playerMov);
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, expv, $time);
      end
   endtask

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("secondsLeft", 32'(secondsLeft), 32'(exp_sec(m)));
      check("running", 32'(running), 32'(m.run));
      check("timeExpired", 32'(timeExpired), 32'(m.pulse));
`ifdef TURN_TIMER_WARN_EN
      check("warn", 32'(warn), 32'(exp_warn(m)));
`endif
      if (timeExpired === 1'b1) dut_pulses++;
      if (m.pulse) mdl_pulses++;
   end

   // Apply the inputs, let n rising edges pass, then return 1 time unit after the last edge.
   task automatic go(input bit ps, input bit pm, input int n);
      playState = ps;
      playerMov = pm;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("reset_sec", 32'(secondsLeft), 32'd3);
      check("reset_run", 32'(running), 32'd0);
      go(0, 0, 2);

      // Full expiry with playState held high
      go(1, 0, 1);
      check("e0_running", 32'(running), 32'd1);
      check("e0_sec", 32'(secondsLeft), 32'd3);
      go(1, 0, 4);
      check("e4_sec", 32'(secondsLeft), 32'd2);
      go(1, 0, 4);
      check("e8_sec", 32'(secondsLeft), 32'd1);
      go(1, 0, 4);
      check("e12_sec", 32'(secondsLeft), 32'd0);
      check("e12_pulse", 32'(timeExpired), 32'd1);
      check("e12_running", 32'(running), 32'd0);
      p0 = dut_pulses;
      go(1, 0, 1);
      check("e13_pulse", 32'(timeExpired), 32'd0);
      go(1, 0, 19);
      check("hold_sec", 32'(secondsLeft), 32'd0);
      check("hold_single_pulse", 32'(dut_pulses - p0), 32'd1);
      go(0, 0, 1);
      check("exp_exit_sec", 32'(secondsLeft), 32'd3);

      // Early move at E0+6, then the turn restarts
      go(1, 0, 1);
      go(1, 0, 6);
      check("early_sec", 32'(secondsLeft), 32'd2);
      go(1, 1, 1);
      check("move_sec", 32'(secondsLeft), 32'd3);
      check("move_running", 32'(running), 32'd0);
      go(1, 0, 1);
      check("restart_running", 32'(running), 32'd1);

      // Move coincides with the final tick
      go(1, 0, 11);
      check("race_pre_sec", 32'(secondsLeft), 32'd1);
      p0 = dut_pulses;
      go(1, 1, 1);
      check("race_sec", 32'(secondsLeft), 32'd3);
      check("race_pulse", 32'(timeExpired), 32'd0);
      go(0, 0, 2);
      check("race_no_pulse", 32'(dut_pulses - p0), 32'd0);

      // Asynchronous reset while secondsLeft=1
      go(1, 0, 1);
      go(1, 0, 9);
      check("rst_pre_sec", 32'(secondsLeft), 32'd1);
      p0 = dut_pulses;
      #2 rst = 1'b0;
      #1;
      check("rst_sec", 32'(secondsLeft), 32'd3);
      check("rst_running", 32'(running), 32'd0);
      check("rst_pulse", 32'(timeExpired), 32'd0);
      playState = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      go(0, 0, 16);
      check("rst_no_pulse", 32'(dut_pulses - p0), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bit ps;
         bit pm;
         ps = ($urandom_range(0, 99) < 93);
         pm = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 rst = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 rst = 1'b1;
         end
         go(ps, pm, $urandom_range(1, 3));
      end
      go(0, 0, 2);
      check("pulse_count", 32'(dut_pulses), 32'(mdl_pulses));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/turn_timer.md
Name: turn_timer

Overview:
- Per-turn countdown timer that sits directly upstream of the game state machine and produces its timeExpired input.
- Counts down whole seconds while the player's turn is active (playState high).
- Reloads when the player moves or the turn ends.
- Exposes the remaining seconds for the display stage.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock cycles per second; the prescaler terminal count is CLK_FREQ_HZ-1. Must be at least 2.
- TURN_SECONDS, 15, seconds allowed per turn. Must be at least 1.
- SEC_W, $clog2(TURN_SECONDS+1), width of secondsLeft. Derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- playState  input  1  high while the game FSM is in PLAY.
- playerMov  input  1  player committed a move this cycle; level-sampled each cycle.
- timeExpired  output  1  one-cycle registered pulse when the turn time runs out.
- secondsLeft  output  SEC_W  remaining whole seconds, registered.
- running  output  1  high while in RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, prescaler=0.
  - secondsLeft=TURN_SECONDS, timeExpired=0, running=0.
  - Reset mid-count aborts the count immediately with no expiry pulse.
- States: IDLE, RUN, EXPIRED.
- IDLE:
  - Holds secondsLeft=TURN_SECONDS and prescaler=0.
  - playState=1 and playerMov=0 -> RUN on the next edge (E0).
  - playState=1 and playerMov=1 together -> stay in IDLE.
- RUN:
  - running=1. The prescaler increments every cycle.
  - tick = (prescaler==CLK_FREQ_HZ-1). On tick the prescaler wraps to 0 and secondsLeft decrements.
  - First decrement happens at edge E0+CLK_FREQ_HZ.
  - Tick with secondsLeft==1:
    - secondsLeft -> 0 and timeExpired=1 on that same edge.
    - Next state is EXPIRED; timeExpired returns to 0 one cycle later.
  - playerMov=1 -> IDLE next edge. Reloads to TURN_SECONDS and prescaler 0. No pulse.
  - playState=0 -> IDLE, same reload, no pulse.
  - Simultaneous playerMov (or playState=0) with the final tick: the move wins. No pulse, secondsLeft reloads.
  - secondsLeft never underflows below 0.
- EXPIRED:
  - running=0, secondsLeft holds 0.
  - playState=0 -> IDLE (reload). playerMov is ignored.
  - Exactly one timeExpired pulse per expiry, even if playState stays high.
- Width rules:
  - Prescaler width is $clog2(CLK_FREQ_HZ).
  - All comparisons are unsigned. The decrement is SEC_W bits and never wraps.
- Outputs are glitch-free: all are registered or pure decodes of the state register.

Optional Feature:
- Macro: TURN_TIMER_WARN_EN.
- Defined:
  - Adds output port warn (1 bit).
  - warn=1 while in RUN and secondsLeft<=3 (or <=TURN_SECONDS if that is smaller), for the display/buzzer.
  - warn resets to 0 and is 0 in IDLE and EXPIRED.
  - warn is registered, updating on the same edge as secondsLeft.
- Not defined: no warn port, no warn logic. All other behaviour is identical.

Decomposition:
- Package turn_timer_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, EXPIRED} timer_state_t.
  - Default constants DEF_CLK_FREQ_HZ and DEF_TURN_SECONDS.
  - WARN_SECONDS=3.
- Sub-module tick_gen (natural split):
  - Parameterised prescaler with clk, rst, clear, enable inputs and a one-cycle tick output.
  - turn_timer instantiates it with clear asserted whenever the state is not RUN.

Test Plan (CLK_FREQ_HZ=4, TURN_SECONDS=3 unless noted):
- Reset: rst=0 mid-RUN with secondsLeft=1 -> immediately secondsLeft=3, running=0, timeExpired=0. No pulse after release.
- Full expiry: playState=1 held -> secondsLeft 3,2,1,0 at E0+4, E0+8, E0+12. timeExpired=1 only for the cycle after E0+12; running=0 from E0+12.
- Early move: playerMov=1 at E0+6 (secondsLeft=2) -> IDLE, secondsLeft=3, no pulse. playState still 1 -> RUN restarts next edge.
- Race: playerMov=1 in the cycle where secondsLeft=1 and the prescaler is at 3 -> no timeExpired, secondsLeft=3.
- Hold in EXPIRED: playState kept 1 for 20 cycles after expiry -> single pulse, secondsLeft stays 0. playState=0 -> IDLE, secondsLeft=3.
- With TURN_TIMER_WARN_EN, TURN_SECONDS=5:
  - warn rises on the edge secondsLeft becomes 3 and stays high through 1.
  - warn drops on expiry and on playerMov.
  - The build without the macro has no warn port.
